// File: rtl/bcd_xs3_pkg.sv
// bcd_xs3_pkg: state encoding, constants and state decode helpers for the serial BCD to Excess-3 converter
package bcd_xs3_pkg;
  typedef enum logic [2:0] {S0, S1C0, S1C1, S2C0, S2C1, S3C0, S3C1} state_t;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [1:0] pos_of(input state_t s);
    return (s == S0) ? 2'd0 : (s inside {S1C0, S1C1}) ? 2'd1 : (s inside {S2C0, S2C1}) ? 2'd2 : 2'd3;
  endfunction
  function automatic logic carry_of(input state_t s);
    return s inside {S1C1, S2C1, S3C1};
  endfunction
  function automatic logic [3:0] xs3_of(input logic [3:0] bcd);
    return bcd + XS3_OFFSET;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that either wraps or saturates at all-ones
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_cnt <= '0;
    else if (i_inc && !(SAT && &r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/bcd_to_xs3_serial.sv
// bcd_to_xs3_serial: LSB-first serial BCD to Excess-3 Mealy converter with parallel digit capture and counters
module bcd_to_xs3_serial
  import bcd_xs3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             X,
  output logic             Z,
  output logic             Dv,
  output logic             Err,
  output logic [3:0]       Bcd,
  output logic [3:0]       Xs3,
  output logic [CNT_W-1:0] DigitCnt,
  output logic [CNT_W-1:0] ErrCnt
);
  state_t     r_state, w_next;
  logic       w_c, w_z, w_done, w_bad;
  logic [1:0] w_pos;
  logic [3:0] r_xsh, r_zsh, r_bcd, r_xs3, w_bcd, w_xs3;
  logic       r_dv, r_err;
  assign w_c   = carry_of(r_state);
  assign w_pos = pos_of(r_state);
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_state <= S0;
    else r_state <= w_next;
  // Serial add of 0011: bit 0 adds 1, bit 1 adds 1 plus carry, bits 2-3 add carry only
  always_comb begin
    w_next = S0;
    w_z    = ~X;
    case (r_state)
      S1C0, S1C1: begin w_z = ~(X ^ w_c); w_next = (X | w_c) ? S2C1 : S2C0; end
      S2C0, S2C1: begin w_z = X ^ w_c; w_next = (X & w_c) ? S3C1 : S3C0; end
      S3C0, S3C1: w_z = X ^ w_c;
      default:    w_next = X ? S1C1 : S1C0;
    endcase
  end
  // Current bit merged into the shift registers gives the completed digit on the last bit
  always_comb begin
    w_bcd        = r_xsh;
    w_xs3        = r_zsh;
    w_bcd[w_pos] = X;
    w_xs3[w_pos] = w_z;
  end
  assign w_done = (w_pos == 2'd3);
  assign w_bad  = w_bcd > BCD_MAX;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_xsh <= '0;
      r_zsh <= '0;
      r_bcd <= '0;
      r_xs3 <= '0;
      r_dv  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_xsh <= w_bcd;
      r_zsh <= w_xs3;
      r_dv  <= w_done;
      r_err <= w_done & w_bad;
      if (w_done) begin
        r_bcd <= w_bcd;
        r_xs3 <= w_xs3;
      end
    end
  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_digit_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_inc (w_done & ~w_bad),
    .o_cnt (DigitCnt)
  );
  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_inc (w_done & w_bad),
    .o_cnt (ErrCnt)
  );
  assign Z   = w_z;
  assign Dv  = r_dv;
  assign Err = r_err;
  assign Bcd = r_bcd;
  assign Xs3 = r_xs3;
endmodule

// File: tb/tb_bcd_to_xs3_serial.sv
// tb_bcd_to_xs3_serial: arithmetic reference model compared every falling edge, plus literal directed vectors
module tb_bcd_to_xs3_serial;
  localparam int CW = 8;
  logic          Clk = 1'b0, Rst, X;
  logic          Z, Dv, Err;
  logic [3:0]    Bcd, Xs3;
  logic [CW-1:0] DigitCnt, ErrCnt;
  int n_chk = 0, n_pass = 0;
  bcd_to_xs3_serial #(.CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .X(X), .Z(Z), .Dv(Dv), .Err(Err),
    .Bcd(Bcd), .Xs3(Xs3), .DigitCnt(DigitCnt), .ErrCnt(ErrCnt)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask
  int         m_pos = 0, m_dc = 0, m_ec = 0;
  logic [3:0] m_acc = '0, m_bcd = '0, m_xs3 = '0;
  logic       m_dv = 1'b0, m_err = 1'b0;
  // Bit k of (partial digit + 3) depends only on bits 0..k, so the Mealy output is plain addition
  always @(negedge Clk) begin
    logic [4:0] sum;
    if (!Rst) begin
      m_pos = 0; m_acc = '0; m_bcd = '0; m_xs3 = '0; m_dv = 0; m_err = 0; m_dc = 0; m_ec = 0;
    end
    sum = {1'b0, m_acc | (4'(X) << m_pos)} + 5'd3;
    check("z", Z, sum[m_pos]);
    check("dv", Dv, m_dv);
    check("err", Err, m_err);
    check("bcd", Bcd, m_bcd);
    check("xs3", Xs3, m_xs3);
    check("digit_cnt", DigitCnt, m_dc);
    check("err_cnt", ErrCnt, m_ec);
    if (Rst) begin
      m_acc = m_acc | (4'(X) << m_pos);
      m_dv  = (m_pos == 3);
      m_err = 0;
      if (m_pos == 3) begin
        m_bcd = m_acc;
        m_xs3 = 4'((m_acc + 3) % 16);
        m_err = m_acc > 9;
        if (m_err) m_ec = (m_ec == (1 << CW) - 1) ? m_ec : m_ec + 1;
        else m_dc = (m_dc + 1) % (1 << CW);
        m_acc = '0;
        m_pos = 0;
      end else m_pos++;
    end
  end
  logic       pend = 0, e_err;
  logic [3:0] e_bcd, e_xs3;
  int         e_dc, e_ec;
  task automatic expect_done(input logic [3:0] b, input logic [3:0] x3, input logic er, input int dc, input int ec);
    e_bcd = b; e_xs3 = x3; e_err = er; e_dc = dc; e_ec = ec; pend = 1;
  endtask
  // Entered and left at posedge+1; bit i of d is driven in the i-th cycle
  task automatic send(input logic [3:0] d, input logic [3:0] ez, input int n = 4);
    for (int i = 0; i < n; i++) begin
      X = d[i];
      @(negedge Clk); #1;
      check("lit_z", Z, ez[i]);
      if (i == 0 && pend) begin
        check("lit_dv", Dv, 1);
        check("lit_bcd", Bcd, e_bcd);
        check("lit_xs3", Xs3, e_xs3);
        check("lit_err", Err, e_err);
        check("lit_digit_cnt", DigitCnt, e_dc);
        check("lit_err_cnt", ErrCnt, e_ec);
        pend = 0;
      end
      @(posedge Clk); #1;
    end
  endtask
  initial begin
    logic [3:0] d;
    Rst = 0; X = 0;
    repeat (2) @(posedge Clk);
    #1 X = 1;
    @(negedge Clk); #1;
    check("rst_z_x1", Z, 0);
    check("rst_dv", Dv, 0);
    check("rst_bcd", Bcd, 0);
    check("rst_xs3", Xs3, 0);
    check("rst_digit_cnt", DigitCnt, 0);
    check("rst_err_cnt", ErrCnt, 0);
    X = 0;
    @(negedge Clk); #1;
    check("rst_z_x0", Z, 1);
    @(posedge Clk); #1 Rst = 1;
    send(4'b0101, 4'b1000);
    expect_done(4'd5, 4'd8, 0, 1, 0);
    send(4'b0000, 4'b0011);
    expect_done(4'd0, 4'd3, 0, 2, 0);
    send(4'b1001, 4'b1100);
    expect_done(4'd9, 4'd12, 0, 3, 0);
    send(4'b1010, 4'b1101);
    expect_done(4'd10, 4'd13, 1, 3, 1);
    send(4'b0011, 4'b0010, 2);
    Rst = 0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1;
    send(4'b0101, 4'b1000);
    expect_done(4'd5, 4'd8, 0, 1, 0);
    send(4'b1111, 4'b0010);
    Rst = 0;
    @(posedge Clk); #1 Rst = 1;
    repeat (300) send(4'b1111, 4'b0010);
    expect_done(4'd15, 4'd2, 1, 0, 255);
    for (int i = 0; i < 256; i++) begin
      d = 4'(i % 10);
      send(d, 4'(d + 3));
    end
    expect_done(4'd5, 4'd8, 0, 0, 255);
    send(4'b0001, 4'b0100);
    for (int i = 0; i < 40000; i++) begin
      Rst = ($urandom_range(9) != 0);
      X = 1'($urandom);
      @(posedge Clk); #1;
    end
    Rst = 1;
    repeat (2) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
